// File: rtl/frequency_meter_pkg.sv
// frequency_meter_pkg: default window/count sizes and FSM state encoding for frequency_meter
package frequency_meter_pkg;
  localparam int GATE_CYCLES_DEF = 50_000_000;
  localparam int COUNT_W_DEF = 18;
  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;
endpackage

// File: rtl/frequency_meter_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus a history flop giving a one-cycle rising-edge pulse
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);
  logic s0, s1, prev;
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) {prev, s1, s0} <= 3'b000;
    else {prev, s1, s0} <= {s1, s0, async_in};
  assign rise_pulse = s1 & ~prev;
endmodule

// File: rtl/frequency_meter.sv
// frequency_meter: counts sig_in rising edges per GATE_CYCLES window; FREQUENCY_METER_OVF_EN adds saturation and ovf
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_out,
  output logic               valid
`ifdef FREQUENCY_METER_OVF_EN
  ,output logic              ovf
`endif
);
  localparam int TW = $clog2(GATE_CYCLES);
  state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [COUNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic rise, run, term;
  sync_edge_detect u_sync (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .async_in  (sig_in),
    .rise_pulse(rise)
  );
  assign run  = (state == MEASURE) && en;
  assign term = timer == TW'(GATE_CYCLES - 1);
`ifdef FREQUENCY_METER_OVF_EN
  logic sat, ovf_acc;
  assign sat     = rise && (&cnt);
  assign cnt_inc = sat ? cnt : cnt + COUNT_W'(rise);
`else
  assign cnt_inc = cnt + COUNT_W'(rise);
`endif
  // IDLE leaves on en, MEASURE leaves on !en: both reduce to following en
  always_comb begin
    state_nx = en ? MEASURE : IDLE;
    timer_nx = (run && !term) ? timer + TW'(1) : '0;
    cnt_nx   = (run && !term) ? cnt_inc : '0;
  end
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      cnt      <= '0;
      freq_out <= '0;
      valid    <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      cnt   <= cnt_nx;
      valid <= run && term;
      if (run && term) freq_out <= cnt_inc;
    end
`ifdef FREQUENCY_METER_OVF_EN
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf_acc <= run && !term && (ovf_acc || sat);
      if (run && term) ovf <= ovf_acc || sat;
    end
`endif
endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: scoreboard bench for frequency_meter (GATE_CYCLES=100; COUNT_W 18 and 4)
module tb_frequency_meter;
  typedef struct {int cyc; int f; bit o;} exp_t;
  logic clk = 1'b0;
  logic reset_n, en, en2, sig, tog;
  logic [17:0] freq_out;
  logic [3:0] freq2;
  logic valid, valid2;
  logic ovf, ovf2;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ph = 0;
  exp_t q[$];
  exp_t q2[$];
  exp_t e1, e2;
  frequency_meter #(.GATE_CYCLES(100), .COUNT_W(18)) dut (
    .clock_in(clk), .reset_n(reset_n), .en(en), .sig_in(sig),
    .freq_out(freq_out), .valid(valid)
`ifdef FREQUENCY_METER_OVF_EN
    , .ovf(ovf)
`endif
  );
  frequency_meter #(.GATE_CYCLES(100), .COUNT_W(4)) dut2 (
    .clock_in(clk), .reset_n(reset_n), .en(en2), .sig_in(sig),
    .freq_out(freq2), .valid(valid2)
`ifdef FREQUENCY_METER_OVF_EN
    , .ovf(ovf2)
`endif
  );
`ifndef FREQUENCY_METER_OVF_EN
  assign ovf = 1'b0;
  assign ovf2 = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (tog) begin
      ph++;
      if (ph % 2 == 0) sig = ~sig;
    end
  always @(negedge clk)
    if (valid) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d freq_out=%0d required no valid", cyc, freq_out);
      end else begin
        e1 = q.pop_front();
        checks++;
        if (cyc != e1.cyc || int'(freq_out) != e1.f || ovf != e1.o) begin
          errors++;
          $display("FAIL window cyc=%0d freq_out=%0d ovf=%0b required cyc=%0d freq_out=%0d ovf=%0b",
                   cyc, freq_out, ovf, e1.cyc, e1.f, e1.o);
        end
      end
    end
  always @(negedge clk)
    if (valid2) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_w4 cyc=%0d freq_out=%0d required no valid", cyc, freq2);
      end else begin
        e2 = q2.pop_front();
        checks++;
        if (cyc != e2.cyc || int'(freq2) != e2.f || ovf2 != e2.o) begin
          errors++;
          $display("FAIL window_w4 cyc=%0d freq_out=%0d ovf=%0b required cyc=%0d freq_out=%0d ovf=%0b",
                   cyc, freq2, ovf2, e2.cyc, e2.f, e2.o);
        end
      end
    end
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic push(input int c, input int f);
    exp_t e;
    e.cyc = c;
    e.f = f;
    e.o = 1'b0;
    q.push_back(e);
  endtask
  initial begin
    int k;
    exp_t e;
    reset_n = 1'b0; en = 1'b0; en2 = 1'b0; sig = 1'b0; tog = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_freq_out", int'(freq_out), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_ovf", int'(ovf), 0);
    reset_n = 1'b1;
    wait_cyc(cyc + 10);
    k = cyc; en = 1'b1; en2 = 1'b1;
    for (int i = 0; i < 3; i++) push(k + 101 + 100 * i, 25);
    for (int i = 0; i < 2; i++) begin
      e.cyc = k + 101 + 100 * i;
`ifdef FREQUENCY_METER_OVF_EN
      e.f = 15; e.o = 1'b1;
`else
      e.f = 9; e.o = 1'b0;
`endif
      q2.push_back(e);
    end
    wait_cyc(k + 202); en2 = 1'b0;
    wait_cyc(k + 302); en = 1'b0; tog = 1'b0; sig = 1'b1;
    wait_cyc(cyc + 5);
    chk("hold_in_idle", int'(freq_out), 25);
    k = cyc; en = 1'b1;
    push(k + 101, 0); push(k + 201, 0);
    wait_cyc(k + 202); en = 1'b0; sig = 1'b0;
    wait_cyc(cyc + 5);
    k = cyc; en = 1'b1;
    push(k + 101, 0);
    wait_cyc(k + 102); en = 1'b0; tog = 1'b1;
    wait_cyc(cyc + 10);
    k = cyc; en = 1'b1;
    push(k + 101, 25);
    wait_cyc(k + 150); en = 1'b0;
    wait_cyc(k + 170);
    chk("hold_after_abort", int'(freq_out), 25);
    k = cyc; en = 1'b1;
    push(k + 101, 25);
    wait_cyc(k + 160); reset_n = 1'b0; en = 1'b0;
    #1;
    chk("async_reset_freq_out", int'(freq_out), 0);
    chk("async_reset_valid", int'(valid), 0);
    wait_cyc(cyc + 2); reset_n = 1'b1;
    wait_cyc(cyc + 5);
    k = cyc; en = 1'b1;
    push(k + 101, 25);
    wait_cyc(k + 102); en = 1'b0; tog = 1'b0; sig = 1'b0;
    wait_cyc(cyc + 5);
    k = cyc; en = 1'b1;
    push(k + 101, 1); push(k + 201, 0);
    wait_cyc(k + 98); sig = 1'b1;
    wait_cyc(k + 202); en = 1'b0;
    wait_cyc(cyc + 5);
    chk("missing_valids", q.size(), 0);
    chk("missing_valids_w4", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
